// File: rtl/sipo_rx_if.sv
// sipo_rx_if - output handshake bundle of the SIPO receiver.
//   dout  : received word (WIDTH bits), driven by the receiver
//   valid : dout holds an unconsumed word
//   ready : consumer accepts dout when high together with valid
// master = receiver side, slave = consumer side.
interface sipo_rx_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             ready;

    modport master (output dout, output valid, input ready);
    modport slave  (input dout, input valid, output ready);
endinterface

// File: rtl/sipo_rx.sv
// sipo_rx - serial-in/parallel-out receiver.
// Samples a framed serial stream (frame start marked by a one-cycle start
// strobe), reassembles WIDTH-bit words and presents them through a
// single-entry valid/ready output register. A word that completes while the
// register is still full and not being drained is dropped and flagged in the
// sticky overrun bit.
//
// Optional feature macro: SIPO_RX_PARITY_EN
//   defined   : frame carries a trailing even-parity bit (FRAME_LEN=WIDTH+1);
//               a failed frame is discarded and pulses parity_err.
//   undefined : FRAME_LEN=WIDTH, parity_err tied low.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      frame strobe, high while frame bit 0 is on din
//   din        serial data
//   clr_ovr    synchronous clear of overrun (a same-edge set wins)
//   rx         output handshake (dout/valid out, ready in)
//   busy       frame reception in progress
//   overrun    sticky: a completed word was dropped
//   parity_err one-cycle pulse after a parity-failed frame
module sipo_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  logic      din,
    input  logic      clr_ovr,
    sipo_rx_if.master rx,
    output logic      busy,
    output logic      overrun,
    output logic      parity_err
);

`ifdef SIPO_RX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int            CW   = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sr, shifted, word;
    logic             done, word_ok;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; a start strobe in SHIFT silently restarts the frame
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = CW'(1);
                end
            end
            SHIFT: begin
                if (start) begin
                    cnt_nxt = CW'(1);
                end else if (cnt == LAST) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    // New bits always enter at the end opposite the first-received bit, so
    // after WIDTH data bits the first one sits at its final position.
    assign shifted = MSB_FIRST ? {sr[WIDTH-2:0], din} : {din, sr[WIDTH-1:1]};

`ifdef SIPO_RX_PARITY_EN
    // Completing edge samples the parity bit: data is already complete in sr.
    assign word    = sr;
    assign word_ok = ~(^sr ^ din);
`else
    // Completing edge samples the last data bit: word is the shifted value.
    assign word    = shifted;
    assign word_ok = 1'b1;
`endif

    // Datapath and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr       <= '0;
            rx.dout  <= '0;
            rx.valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (start || state == SHIFT)
                sr <= shifted;

            // A completing word may replace one being consumed on this edge
            if (done && word_ok && (!rx.valid || rx.ready)) begin
                rx.dout  <= word;
                rx.valid <= 1'b1;
            end else if (rx.valid && rx.ready) begin
                rx.valid <= 1'b0;
            end

            if (done && word_ok && rx.valid && !rx.ready)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

`ifdef SIPO_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) parity_err <= 1'b0;
        else      parity_err <= done && !word_ok;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;
    localparam int W   = 8;
    localparam bit MSB = 1'b1;
`ifdef SIPO_RX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, din = 1'b0, clr_ovr = 1'b0, ready = 1'b0;
    logic busy, overrun, parity_err;

    sipo_rx_if #(.WIDTH(W)) rxi ();
    assign rxi.ready = ready;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .clr_ovr(clr_ovr),
        .rx(rxi), .busy(busy), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int rdy_pct  = 0;
    int clr_pct  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level) ----------------
    bit            bits[$];          // bits of the frame in flight
    logic [W-1:0]  exp_q[$];         // words expected to be presented
    bit            m_valid, m_ovr, m_perr, m_busy;

    always @(posedge clk or negedge rst) begin : model
        bit            done, ok;
        logic [W-1:0]  w;
        int            ones;
        if (!rst) begin
            bits.delete(); exp_q.delete();
            m_valid = 0; m_ovr = 0; m_perr = 0; m_busy = 0;
        end else begin
            done = 0; ok = 1; w = '0;
            if (start) begin
                bits.delete(); bits.push_back(din);
            end else if (bits.size() > 0) begin
                bits.push_back(din);
            end
            if (bits.size() == FL) begin
                done = 1;
                ones = 0;
                for (int i = 0; i < FL; i++) ones += int'(bits[i]);
                for (int i = 0; i < W; i++) begin
                    if (MSB) w[W-1-i] = bits[i];
                    else     w[i]     = bits[i];
                end
`ifdef SIPO_RX_PARITY_EN
                ok = (ones % 2) == 0;
`endif
                bits.delete();
            end
            m_perr = done && !ok;
            if (done && ok && m_valid && !ready) begin
                m_ovr = 1;
            end else begin
                if (done && ok) begin
                    exp_q.push_back(w);
                    m_valid = 1;
                end else if (m_valid && ready) begin
                    m_valid = 0;
                end
                if (clr_ovr) m_ovr = 0;
            end
            m_busy = bits.size() > 0;
        end
    end

    // ---------------- monitor (mid-cycle sampling) ----------------
    bit           prev_valid = 0, prev_hs = 0;
    logic [W-1:0] cur;

    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 0; prev_hs = 0;
        end else begin
            if (rxi.valid && (!prev_valid || prev_hs)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(rxi.dout), 32'hFFFF_FFFF);
                end else begin
                    cur = exp_q.pop_front();
                    chk("dout_word", 32'(rxi.dout), 32'(cur));
                end
            end else if (rxi.valid) begin
                chk("dout_stable", 32'(rxi.dout), 32'(cur));
            end
            chk("valid", 32'(rxi.valid), 32'(m_valid));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("parity_err", 32'(parity_err), 32'(m_perr));
            prev_valid = rxi.valid;
            prev_hs    = rxi.valid && ready;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk); #1;
        ready   = ($urandom_range(99) < rdy_pct);
        clr_ovr = ($urandom_range(99) < clr_pct);
    endtask

    task automatic send_frame(input logic [W-1:0] data, input int nbits, input bit bad_par);
        for (int i = 0; i < nbits; i++) begin
            start = (i == 0);
            if (i < W) din = MSB ? data[W-1-i] : data[i];
            else       din = (^data) ^ bad_par;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din = 1'($urandom);
            tick();
        end
    endtask

    initial begin
        // reset / idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_dout", 32'(rxi.dout), 32'h0);
        chk("rst_valid", 32'(rxi.valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        @(posedge clk); #1;

        // basic receive, then single-cycle ready pulse
        rdy_pct = 0;
        send_frame(8'hAA, FL, 0);
        idle(2);
        ready = 1'b1;
        tick();
        idle(2);

        // back-to-back with ready held high
        rdy_pct = 100; ready = 1'b1;
        send_frame(8'hAA, FL, 0);
        send_frame(8'h3C, FL, 0);
        idle(2);

        // overrun, then clear
        rdy_pct = 0; ready = 1'b0;
        send_frame(8'h11, FL, 0);
        send_frame(8'h22, FL, 0);
        idle(1);
        clr_ovr = 1'b1;
        tick();
        idle(1);
        rdy_pct = 100; ready = 1'b1;
        idle(2);

        // restart mid-frame
        rdy_pct = 0; ready = 1'b0;
        send_frame(8'hFF, 3, 0);
        send_frame(8'h5A, FL, 0);
        idle(2);
        ready = 1'b1;
        tick();

`ifdef SIPO_RX_PARITY_EN
        // parity good then bad (8'hAB with parity bit 0)
        send_frame(8'hAA, FL, 0);
        idle(1);
        send_frame(8'hAB, FL, 1);
        idle(2);
        ready = 1'b1;
        tick();
`endif

        // randomized frames
        for (int f = 0; f < 60; f++) begin
            case ($urandom_range(3))
                0: rdy_pct = 0;
                1: rdy_pct = 50;
                2: rdy_pct = 90;
                default: rdy_pct = 100;
            endcase
            clr_pct = 5;
            if ($urandom_range(4) == 0)
                send_frame(W'($urandom), $urandom_range(FL-1, 1), 0);
            send_frame(W'($urandom), FL, ($urandom_range(5) == 0));
            idle($urandom_range(2));
        end
        clr_pct = 0;

        // asynchronous reset mid-frame
        rdy_pct = 0;
        send_frame(8'hC3, FL, 0);
        send_frame(8'h96, 4, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_dout", 32'(rxi.dout), 32'h0);
        chk("arst_valid", 32'(rxi.valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_overrun", 32'(overrun), 32'h0);
        chk("arst_parity_err", 32'(parity_err), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // one more frame after reset, then drain
        send_frame(8'h81, FL, 0);
        rdy_pct = 100; ready = 1'b1;
        idle(3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out receiver that sits directly downstream of the PISO shifter. It samples a framed serial bit stream (frame start marked by a one-cycle `start` strobe), reassembles WIDTH-bit words, and presents each word on a valid/ready output port. A single-entry output register provides buffering, and a sticky flag reports overrun.

## Interface
- `WIDTH`, 8, data word width in bits (≥2)
- `MSB_FIRST`, 1, 1: first received bit is word bit WIDTH-1; 0: first bit is bit 0
- `clk`  input  1  clock, all sampling on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `start`  input  1  frame strobe, high in the cycle the first frame bit is on `din`
- `din`  input  1  serial data
- `ready`  input  1  consumer accepts `dout` when high with `valid`
- `clr_ovr`  input  1  synchronous clear of `overrun`
- `dout`  output  WIDTH  received word
- `valid`  output  1  `dout` holds an unconsumed word
- `busy`  output  1  frame reception in progress
- `overrun`  output  1  sticky: a completed word was dropped
- `parity_err`  output  1  one-cycle pulse on parity failure (see Configuration)

## Operation
- Reset (`rst`=0, any time, asynchronous): state IDLE, bit counter 0, shift register 0, `dout`=0, `valid`=0, `busy`=0, `overrun`=0, `parity_err`=0. A partial frame is discarded. The output word is lost.
- FSM states:
  - IDLE: `busy`=0. When `start`=1 at an edge, capture `din` as frame bit 0, set counter=1, and go to SHIFT.
  - SHIFT: `busy`=1. Capture `din` on each edge and increment the counter. On the edge that captures bit FRAME_LEN-1, the frame completes and the FSM returns to IDLE. FRAME_LEN=WIDTH, or WIDTH+1 with parity.
- `start`=1 while in SHIFT aborts the partial frame. The sampled bit becomes bit 0 of a new frame (counter=1). No flag is raised.
- Bit order: MSB_FIRST=1 shifts left, LSB entering. MSB_FIRST=0 shifts right, MSB entering.
- Frame completion, evaluated on the same edge:
  - `valid`=0, or `valid`=1 and `ready`=1: load `dout` and set `valid`=1.
  - `valid`=1 and `ready`=0: word dropped, `dout` unchanged, `overrun` set.
- `valid`=1 and `ready`=1 with no completion: `valid` clears. `dout` holds its value.
- `overrun`: cleared by `clr_ovr`=1. If a set and a clear occur on the same edge, set wins.
- `dout` is stable while `valid`=1.

## Timing
- Bit i of a frame is sampled at edge k+i, where edge k samples `start`=1.
- `valid` rises and `dout` updates after edge k+FRAME_LEN-1. Latency from the last bit to `valid` is 0 cycles.
- Back-to-back frames: `start` may be asserted at edge k+FRAME_LEN. No idle gap is required.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Throughput: one word per FRAME_LEN cycles, sustained when `ready` is held high.

## Configuration
- Macro: `SIPO_RX_PARITY_EN`.
- Defined:
  - FRAME_LEN=WIDTH+1. The final bit is an even-parity bit over the data bits, so the XOR of data and parity is 0.
  - On mismatch: the word is not loaded, `valid` is unaffected, `parity_err` pulses high for one cycle after the completing edge, and `overrun` is not set.
  - A parity-failed frame never causes an overrun.
- Undefined:
  - FRAME_LEN=WIDTH.
  - `parity_err` is tied to 0.

## Test plan
- Reset/idle: hold `rst`=0 for 2 cycles, then release → `dout`=8'h00, `valid`=`busy`=`overrun`=0. Asserting `rst` mid-frame returns all outputs to these values immediately.
- Basic receive (WIDTH=8, MSB_FIRST=1, parity off): `start` at edge k, `din`=1,0,1,0,1,0,1,0, `ready`=0 → `valid`=1 and `dout`=8'hAA after edge k+7. Pulsing `ready` for 1 cycle clears `valid` and leaves `dout` at 8'hAA.
- Back-to-back with `ready`=1: frames 8'hAA then 8'h3C with no gap → `dout`=8'hAA after edge k+7, `dout`=8'h3C after edge k+15, `valid` stays high across the boundary, `overrun`=0.
- Overrun: `ready`=0, two full frames 8'h11 then 8'h22 → `dout` stays 8'h11, `overrun`=1 after the second frame completes. `clr_ovr` for 1 cycle → `overrun`=0.
- Restart: `start` at edge k, then `start` again at edge k+3, followed by 8 bits of 8'h5A → `dout`=8'h5A after edge k+10. The partial frame produces no `valid` and no flag.
- Parity (`SIPO_RX_PARITY_EN` defined): frame 8'hAA with parity 0 → `valid`=1, `dout`=8'hAA. Frame 8'hAB with parity 0 → `parity_err` 1-cycle pulse, `dout`/`valid` unchanged, `overrun`=0.
